// File: rtl/gd6809_dma_arb_if.sv
// Bus-sharing handshake between the DMA arbiter, the 6809E core and the requesters.
interface gd6809_dma_arb_if #(
    parameter int unsigned NREQ = 4
);
    logic            E;
    logic            BA;
    logic            BS;
    logic [NREQ-1:0] REQ;
    logic            FAULT_CLR;
    logic            nHALT_OUT;
    logic [NREQ-1:0] GNT;
    logic            BUS_OWNED;
    logic            FAULT;

    // Environment side: core status, requests and E.
    modport master (
        output E, BA, BS, REQ, FAULT_CLR,
        input  nHALT_OUT, GNT, BUS_OWNED, FAULT
    );

    // Arbiter side.
    modport slave (
        input  E, BA, BS, REQ, FAULT_CLR,
        output nHALT_OUT, GNT, BUS_OWNED, FAULT
    );
endinterface

// File: rtl/gd6809_dma_arb.sv
// Round-robin DMA bus arbiter for the soft 6809E: halts the core, grants the
// bus to one requester at a time with a burst limit, then hands it back.
// Everything is paced by falling edges of E, detected in the fpgaclk domain.
module gd6809_dma_arb #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned HALT_TIMEOUT = 64
) (
    input  logic                    fpgaclk,
    input  logic                    RESET,
    gd6809_dma_arb_if.slave         bus
);

    localparam int unsigned PTR_W   = (NREQ > 1)         ? $clog2(NREQ)         : 1;
    localparam int unsigned TMO_W   = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
    localparam int unsigned BURST_W = (MAX_BURST > 1)    ? $clog2(MAX_BURST)    : 1;

    localparam logic [PTR_W-1:0]   LAST_IDX   = PTR_W'(NREQ - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(HALT_TIMEOUT - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HALT_WAIT = 3'd1,
        S_GRANT     = 3'd2,
        S_GAP       = 3'd3,
        S_RELEASE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         e_sync_q, e_sync_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   winner_q, winner_d;
    logic               nhalt_q, nhalt_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               bus_owned_q, bus_owned_d;
    logic               fault_q, fault_d;

    logic               efall;
    logic               arb_found;
    logic [PTR_W-1:0]   arb_idx;
    logic               fault_set;
    logic               do_arb;
    logic               end_grant;
    logic               tmo_clr;
    logic               tmo_inc;
    logic               burst_inc;

    // E synchroniser: bit0 = E_s1, bit1 = E_s2, bit2 = E_s3.
    always_comb begin
        e_sync_d = {e_sync_q[1:0], bus.E};
    end

    assign efall = e_sync_q[2] & ~e_sync_q[1];

    // Round-robin search: first pending request at or after rr_ptr, wrapping mod NREQ.
    always_comb begin
        int unsigned k;
        arb_found = 1'b0;
        arb_idx   = '0;
        k         = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = 32'(rr_ptr_q) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (!arb_found && bus.REQ[PTR_W'(k)]) begin
                arb_found = 1'b1;
                arb_idx   = PTR_W'(k);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge fpgaclk or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            e_sync_q    <= '0;
            tmo_q       <= '0;
            burst_q     <= '0;
            rr_ptr_q    <= '0;
            winner_q    <= '0;
            nhalt_q     <= 1'b1;
            gnt_q       <= '0;
            bus_owned_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            e_sync_q    <= e_sync_d;
            tmo_q       <= tmo_d;
            burst_q     <= burst_d;
            rr_ptr_q    <= rr_ptr_d;
            winner_q    <= winner_d;
            nhalt_q     <= nhalt_d;
            gnt_q       <= gnt_d;
            bus_owned_q <= bus_owned_d;
            fault_q     <= fault_d;
        end
    end

    // Next-state logic; BA, BS and REQ only matter on an E falling edge.
    always_comb begin
        state_d   = state_q;
        fault_set = 1'b0;
        do_arb    = 1'b0;
        end_grant = 1'b0;
        tmo_clr   = 1'b0;
        tmo_inc   = 1'b0;
        burst_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (efall && (|bus.REQ)) begin
                    state_d = S_HALT_WAIT;
                    tmo_clr = 1'b1;
                end
            end
            S_HALT_WAIT: begin
                if (efall) begin
                    if (bus.BA && bus.BS && arb_found) begin
                        state_d = S_GRANT;
                        do_arb  = 1'b1;
                    end else if (!(|bus.REQ)) begin
                        state_d = S_RELEASE;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d   = S_IDLE;
                        fault_set = 1'b1;
                    end else begin
                        tmo_inc = 1'b1;
                    end
                end
            end
            S_GRANT: begin
                if (efall) begin
                    if (!bus.BA) begin
                        state_d   = S_RELEASE;
                        fault_set = 1'b1;
                    end else if (!bus.REQ[winner_q] || (burst_q == BURST_LAST)) begin
                        state_d   = S_GAP;
                        end_grant = 1'b1;
                    end else begin
                        burst_inc = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (efall) begin
                    if (!bus.BA) begin
                        state_d   = S_RELEASE;
                        fault_set = 1'b1;
                    end else if (arb_found) begin
                        state_d = S_GRANT;
                        do_arb  = 1'b1;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                if (efall && !bus.BA) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Counters, pointer and registered outputs derived from the chosen transition.
    always_comb begin
        tmo_d    = tmo_q;
        burst_d  = burst_q;
        rr_ptr_d = rr_ptr_q;
        winner_d = winner_q;
        if (tmo_clr) begin
            tmo_d = '0;
        end else if (tmo_inc) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        if (do_arb) begin
            burst_d  = '0;
            winner_d = arb_idx;
        end else if (burst_inc) begin
            burst_d = burst_q + BURST_W'(1);
        end
        if (end_grant) begin
            rr_ptr_d = (winner_q == LAST_IDX) ? '0 : winner_q + PTR_W'(1);
        end
        bus_owned_d = (state_d == S_GRANT);
        gnt_d       = (state_d == S_GRANT) ? (NREQ'(1'b1) << winner_d) : '0;
        nhalt_d     = !((state_d == S_HALT_WAIT) || (state_d == S_GRANT) || (state_d == S_GAP));
        fault_d     = fault_set | (fault_q & ~bus.FAULT_CLR);
    end

    assign bus.nHALT_OUT = nhalt_q;
    assign bus.GNT       = gnt_q;
    assign bus.BUS_OWNED = bus_owned_q;
    assign bus.FAULT     = fault_q;

endmodule

// File: tb/tb_gd6809_dma_arb.sv
// Self-checking bench for gd6809_dma_arb: directed vector tables, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_gd6809_dma_arb;

    localparam int NREQ = 4;
    localparam int MB   = 4;
    localparam int HT   = 8;

    logic fpgaclk;
    logic RESET;

    gd6809_dma_arb_if #(.NREQ(NREQ)) bus ();

    gd6809_dma_arb #(
        .NREQ(NREQ),
        .MAX_BURST(MB),
        .HALT_TIMEOUT(HT)
    ) dut (
        .fpgaclk(fpgaclk),
        .RESET(RESET),
        .bus(bus)
    );

    initial fpgaclk = 1'b0;
    always #5 fpgaclk = ~fpgaclk;

    int n_tests;
    int n_fail;

    // {nHALT_OUT, BUS_OWNED, FAULT, GNT[3:0]}
    function automatic logic [6:0] dut_out();
        return {bus.nHALT_OUT, bus.BUS_OWNED, bus.FAULT, bus.GNT};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {nhalt,owned,fault,gnt}=%b_%b_%b_%b want %b_%b_%b_%b",
                     name, act[6], act[5], act[4], act[3:0], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_HALTING, M_OWNED, M_TURN, M_HANDBACK} mstate_t;
    mstate_t m_st;
    int      m_wait;    // E cycles spent waiting for BA&BS
    int      m_len;     // E cycles the current owner has held the bus
    int      m_ptr;     // requester with highest priority next time
    int      m_who;
    logic    m_fault;

    function automatic int pick(input logic [3:0] r, input int from);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (from + k) % NREQ;
            if (r[2'(j)]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_wait = 0; m_len = 0; m_ptr = 0; m_who = 0; m_fault = 1'b0;
    endtask

    task automatic model_efall(input logic ba, input logic bs, input logic [3:0] req);
        case (m_st)
            M_IDLE: if (req != 0) begin m_st = M_HALTING; m_wait = 0; end
            M_HALTING: begin
                if (ba && bs && req != 0) begin
                    m_who = pick(req, m_ptr); m_len = 1; m_st = M_OWNED;
                end else if (req == 0) m_st = M_HANDBACK;
                else if (m_wait + 1 == HT) begin m_fault = 1'b1; m_st = M_IDLE; end
                else m_wait++;
            end
            M_OWNED: begin
                if (!ba) begin m_fault = 1'b1; m_st = M_HANDBACK; end
                else if (!req[2'(m_who)] || m_len == MB) begin
                    m_ptr = (m_who + 1) % NREQ; m_st = M_TURN;
                end else m_len++;
            end
            M_TURN: begin
                if (!ba) begin m_fault = 1'b1; m_st = M_HANDBACK; end
                else if (req != 0) begin m_who = pick(req, m_ptr); m_len = 1; m_st = M_OWNED; end
                else m_st = M_HANDBACK;
            end
            M_HANDBACK: if (!ba) m_st = M_IDLE;
            default: m_st = M_IDLE;
        endcase
    endtask

    function automatic logic [6:0] model_out();
        logic       nh;
        logic       own;
        logic [3:0] g;
        nh  = (m_st == M_IDLE) || (m_st == M_HANDBACK);
        own = (m_st == M_OWNED);
        g   = own ? (4'b0001 << m_who) : 4'b0000;
        return {nh, own, m_fault, g};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge fpgaclk);
        RESET = 1'b1;
        bus.E = 1'b0; bus.BA = 1'b0; bus.BS = 1'b0; bus.REQ = '0; bus.FAULT_CLR = 1'b0;
        repeat (3) @(negedge fpgaclk);
        RESET = 1'b0;
        repeat (4) @(negedge fpgaclk);
        model_reset();
    endtask

    // One E period (3 clocks high, 3 low); inputs change while E is high and
    // outputs are settled at the returning negedge.
    task automatic ecycle(input logic ba, input logic bs, input logic [3:0] req, input logic clr);
        bus.E = 1'b1; bus.BA = ba; bus.BS = bs; bus.REQ = req;
        if (clr) begin
            bus.FAULT_CLR = 1'b1;
            @(negedge fpgaclk);
            bus.FAULT_CLR = 1'b0;
            repeat (2) @(negedge fpgaclk);
        end else begin
            repeat (3) @(negedge fpgaclk);
        end
        bus.E = 1'b0;
        repeat (3) @(negedge fpgaclk);
    endtask

    typedef struct {
        int         grp;
        logic       ba;
        logic       bs;
        logic [3:0] req;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int grp, input logic ba, input logic bs, input logic [3:0] req,
                                input logic nh, input logic own, input logic flt, input logic [3:0] g);
        vec_t v;
        v.grp = grp; v.ba = ba; v.bs = bs; v.req = req; v.exp = {nh, own, flt, g};
        return v;
    endfunction

    initial begin
        int         cur_grp;
        logic [3:0] rreq;
        logic       rba, rbs, rclr;

        n_tests = 0;
        n_fail  = 0;
        RESET   = 1'b1;
        bus.E = 1'b0; bus.BA = 1'b0; bus.BS = 1'b0; bus.REQ = '0; bus.FAULT_CLR = 1'b0;

        // Group 1: single request, then a second request proving the pointer advanced.
        tbl.push_back(mk(1, 0, 0, 4'b0001, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 0, 0, 4'b0001, 0, 0, 0, 4'b0000));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 1, 4'b0001, 0, 1, 0, 4'b0001));
        tbl.push_back(mk(1, 1, 1, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 1, 1, 4'b0000, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 0, 0, 4'b0000, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 0, 0, 4'b0011, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 1, 1, 4'b0011, 0, 1, 0, 4'b0010));
        tbl.push_back(mk(1, 1, 1, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 1, 1, 4'b0000, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 0, 0, 4'b0000, 1, 0, 0, 4'b0000));
        // Group 2: round robin over 1011 with bursts of MB.
        tbl.push_back(mk(2, 0, 0, 4'b1011, 0, 0, 0, 4'b0000));
        for (int i = 0; i < MB; i++) tbl.push_back(mk(2, 1, 1, 4'b1011, 0, 1, 0, 4'b0001));
        tbl.push_back(mk(2, 1, 1, 4'b1011, 0, 0, 0, 4'b0000));
        for (int i = 0; i < MB; i++) tbl.push_back(mk(2, 1, 1, 4'b1011, 0, 1, 0, 4'b0010));
        tbl.push_back(mk(2, 1, 1, 4'b1011, 0, 0, 0, 4'b0000));
        for (int i = 0; i < MB; i++) tbl.push_back(mk(2, 1, 1, 4'b1011, 0, 1, 0, 4'b1000));
        tbl.push_back(mk(2, 1, 1, 4'b1011, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(2, 1, 1, 4'b1011, 0, 1, 0, 4'b0001));
        // Group 3: halt timeout on the HT-th efall after nHALT asserts.
        tbl.push_back(mk(3, 0, 0, 4'b0100, 0, 0, 0, 4'b0000));
        for (int i = 0; i < HT - 1; i++) tbl.push_back(mk(3, 0, 0, 4'b0100, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(3, 0, 0, 4'b0100, 1, 0, 1, 4'b0000));
        tbl.push_back(mk(3, 0, 0, 4'b0000, 1, 0, 1, 4'b0000));

        do_reset();
        check("reset_state", dut_out(), 7'b1_0_0_0000);

        cur_grp = 1;
        foreach (tbl[i]) begin
            if (tbl[i].grp != cur_grp) begin
                cur_grp = tbl[i].grp;
                do_reset();
            end
            ecycle(tbl[i].ba, tbl[i].bs, tbl[i].req, 1'b0);
            check($sformatf("tbl_g%0d_row%0d", tbl[i].grp, i), dut_out(), tbl[i].exp);
        end

        // Fault stays latched through idle, then clears on FAULT_CLR.
        ecycle(0, 0, 4'b0000, 1'b1);
        check("fault_clr", dut_out(), 7'b1_0_0_0000);

        // Lost halt during a grant.
        do_reset();
        ecycle(0, 0, 4'b0010, 1'b0);
        ecycle(1, 1, 4'b0010, 1'b0);
        check("lost_pre_grant", dut_out(), 7'b0_1_0_0010);
        bus.E = 1'b1; bus.BA = 1'b0; bus.BS = 1'b0;
        repeat (3) @(negedge fpgaclk);
        bus.E = 1'b0;
        repeat (2) @(negedge fpgaclk);
        check("lost_before_edge", dut_out(), 7'b0_1_0_0010);
        @(negedge fpgaclk);
        check("lost_after_edge", dut_out(), 7'b1_0_1_0000);
        ecycle(0, 0, 4'b0010, 1'b0);
        check("lost_release_idle", dut_out(), 7'b1_0_1_0000);
        ecycle(0, 0, 4'b0010, 1'b0);
        check("lost_rehalt_from_idle", dut_out(), 7'b0_0_1_0000);

        // Async reset in the middle of a grant.
        do_reset();
        ecycle(0, 0, 4'b0010, 1'b0);
        ecycle(1, 1, 4'b0010, 1'b0);
        check("areset_pre", dut_out(), 7'b0_1_0_0010);
        bus.E = 1'b1;
        #2;
        RESET = 1'b1;
        #1;
        check("areset_immediate", dut_out(), 7'b1_0_0_0000);
        do_reset();

        // One-clock glitch on E yields a single efall: IDLE -> HALT_WAIT, no grant.
        @(negedge fpgaclk);
        bus.BA = 1'b1; bus.BS = 1'b1; bus.REQ = 4'b0001; bus.E = 1'b1;
        @(negedge fpgaclk);
        bus.E = 1'b0;
        repeat (20) @(negedge fpgaclk);
        check("e_glitch", dut_out(), 7'b0_0_0_0000);

        // Randomized run against the model.
        do_reset();
        rreq = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3) == 0) rreq = 4'($urandom_range(15));
            rba  = ($urandom_range(7) != 0);
            rbs  = ($urandom_range(7) != 0);
            rclr = ($urandom_range(15) == 0);
            ecycle(rba, rbs, rreq, rclr);
            if (rclr) m_fault = 1'b0;
            model_efall(rba, rbs, rreq);
            check($sformatf("rand_%0d", n), dut_out(), model_out());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gd6809_dma_arb.md
Name: gd6809_dma_arb

Overview:
- Bus-sharing controller for the soft 6809E socket: lets up to NREQ external DMA/video requesters take the 6809 bus.
- Halts the CPU core via nHALT and waits for the bus-grant acknowledge (BA=1, BS=1).
- Hands the bus to one requester at a time, round-robin, with a burst limit.
- Releases nHALT and waits for the core to take the bus back. Runs in the fast FPGA clock domain; all sequencing is paced by falling edges of E.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum consecutive E cycles granted to one requester (>=1).
- HALT_TIMEOUT, 64, E cycles allowed between nHALT assertion and BA&BS acknowledge (>=2).

Ports:
- fpgaclk  input  1  fast sampling clock (6x oscillator clock).
- RESET  input  1  asynchronous, active-high reset.
- E  input  1  bus E clock, unsynchronised.
- BA  input  1  bus-available from CPU core.
- BS  input  1  bus-status from CPU core.
- REQ  input  NREQ  level bus requests; held high until granted and finished.
- FAULT_CLR  input  1  synchronous pulse; clears FAULT.
- nHALT_OUT  output  1  active-low halt to CPU core (ANDed with board nHALT outside).
- GNT  output  NREQ  one-hot grant; at most one bit set.
- BUS_OWNED  output  1  high while any GNT bit is set.
- FAULT  output  1  sticky error flag.

Behaviour:
- E sync and pacing:
  - E passes through 3 flops E_s1..E_s3.
  - efall = E_s3 & ~E_s2, one fpgaclk wide.
  - BA, BS and REQ are sampled only on efall.
  - All state and output changes occur on the fpgaclk edge after efall. Outputs are registered and constant between efalls.
- Reset (async, any time including mid-grant): state IDLE, nHALT_OUT=1, GNT=0, BUS_OWNED=0, FAULT=0, rr_ptr=0, counters=0.
- IDLE: on efall with |REQ, go to HALT_WAIT, drive nHALT_OUT=0, tmo=0.
- HALT_WAIT, on efall:
  - BA&BS: go to GRANT. Winner = first set REQ bit searching rr_ptr, rr_ptr+1, ... mod NREQ. GNT=onehot(winner), burst=0.
  - Else if REQ==0 (request withdrawn): go to RELEASE.
  - Else if tmo==HALT_TIMEOUT-1: set FAULT, nHALT_OUT=1, go to IDLE.
  - Else tmo++.
  - BA&BS takes precedence over withdrawal and timeout on the same efall.
- GRANT, on efall:
  - BA==0 (core lost halt): GNT=0, set FAULT, go to RELEASE.
  - Else if REQ[winner]==0 or burst==MAX_BURST-1: GNT=0, rr_ptr=(winner+1) mod NREQ, go to GAP.
  - Else burst++.
  - burst saturates at MAX_BURST-1 and never wraps.
- GAP: exactly one E cycle with GNT=0 and nHALT_OUT still 0 (driver turnaround). On the next efall:
  - BA==0: set FAULT, go to RELEASE.
  - Else if |REQ: re-arbitrate from the updated rr_ptr, go to GRANT, burst=0. The same requester may win if it is the only one pending.
  - Else go to RELEASE.
- RELEASE: nHALT_OUT=1. On efall with BA==0, go to IDLE. REQ is ignored in RELEASE. There is no timeout in RELEASE.
- Outputs: BUS_OWNED = (state==GRANT), registered. GNT is never set outside GRANT.
- FAULT: set only as listed above. Cleared by FAULT_CLR or RESET. Set has priority over clear in the same fpgaclk.
- Widths:
  - burst is clog2(MAX_BURST) bits (min 1).
  - tmo is clog2(HALT_TIMEOUT) bits.
  - rr_ptr is clog2(NREQ) bits.
  - Modulo wrap is explicit for non-power-of-2 NREQ.
- Encoding: IDLE, HALT_WAIT, GRANT, GAP, RELEASE. Unused encodings return to IDLE with nHALT_OUT=1.

Test Plan:
1. Single request: NREQ=4, REQ=0001. Model core sets BA=BS=1 two efalls after nHALT_OUT falls; REQ drops after 3 granted E cycles.
   - Required: GNT=0001 for exactly 3 efalls, then 1 GAP cycle, then RELEASE with nHALT_OUT=1.
   - IDLE after BA=0; rr_ptr=1; FAULT=0.
2. Round robin: REQ=1011 held, MAX_BURST=4.
   - Required grant order 0001, 0010, 1000, 0001. Each grant lasts 4 E cycles, separated by one GAP with GNT=0000.
   - nHALT_OUT stays 0 throughout.
3. Halt timeout: REQ=0100, core never raises BA, HALT_TIMEOUT=8.
   - Required: FAULT=1 and nHALT_OUT=1 on the 8th efall after assertion; state IDLE.
   - A FAULT_CLR pulse then yields FAULT=0.
4. Lost halt: BA drops to 0 during GRANT.
   - Required: GNT=0000 and FAULT=1 one fpgaclk after that efall; nHALT_OUT=1.
   - IDLE on the next efall with BA=0.
5. Async reset mid-grant: assert RESET between efalls while GNT=0010.
   - Required: GNT=0000, nHALT_OUT=1, BUS_OWNED=0, FAULT=0 immediately, without waiting for a fpgaclk edge.
6. E glitch: a 1-fpgaclk-wide high pulse on E.
   - Required: at most one efall generated, and no state change beyond that single efall.
